// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES pad I/O sequencer.
// Default widths match the 128-bit AES datapath; the top may override them.
package aes_pkg;
    localparam int AES_DATA_W = 128;
    localparam int AES_NIB_W  = 4;
    localparam int AES_OUT_W  = 8;
    localparam int NIBBLES    = AES_DATA_W / AES_NIB_W;
    localparam int BYTES      = AES_DATA_W / AES_OUT_W;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;
endpackage

// File: rtl/aes_nib_shifter.sv
// Shift-in register: each shift moves the word left by one nibble, new nibble at the LSB.
// One-cycle capture; holds its value whenever shift is low.
module aes_nib_shifter #(
    parameter int DATA_W = 128,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic [NIB_W-1:0]  nib,
    output logic [DATA_W-1:0] word
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (shift) begin
            word <= {word[DATA_W-NIB_W-1:0], nib};
        end
    end
endmodule

// File: rtl/aes_io_sequencer.sv
// Pad-side sequencer: nibble load of block/key, core start/wait with timeout, byte unload.
// Start 32 cycles after the first nibble; en low stalls the load; no backpressure on unload.
module aes_io_sequencer
    import aes_pkg::*;
#(
    parameter int DATA_W   = AES_DATA_W,
    parameter int NIB_W    = AES_NIB_W,
    parameter int OUT_W    = AES_OUT_W,
    parameter int WAIT_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              test,
    input  logic [NIB_W-1:0]  block,
    input  logic [NIB_W-1:0]  key,
    output logic [OUT_W-1:0]  result,
    output logic              done,
    output logic              err,
    output logic              core_start,
    output logic [DATA_W-1:0] core_block,
    output logic [DATA_W-1:0] core_key,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result
);
    localparam int NIB_TOTAL  = DATA_W / NIB_W;
    localparam int BYTE_TOTAL = DATA_W / OUT_W;
    localparam int NIB_CW     = $clog2(NIB_TOTAL) + 1;
    localparam int WAIT_CW    = $clog2(WAIT_MAX) + 1;
    localparam int BYTE_CW    = $clog2(BYTE_TOTAL) + 1;

    localparam logic [NIB_CW-1:0]  NIB_ONE   = NIB_CW'(1);
    localparam logic [NIB_CW-1:0]  NIB_LAST  = NIB_CW'(NIB_TOTAL - 1);
    localparam logic [WAIT_CW-1:0] WAIT_ONE  = WAIT_CW'(1);
    localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(WAIT_MAX - 1);
    localparam logic [BYTE_CW-1:0] BYTE_ONE  = BYTE_CW'(1);
    localparam logic [BYTE_CW-1:0] BYTE_LAST = BYTE_CW'(BYTE_TOTAL - 1);

    logic [2:0]         state;
    logic               test_q;
    logic [NIB_CW-1:0]  nib_cnt;
    logic [WAIT_CW-1:0] wait_cnt;
    logic [BYTE_CW-1:0] byte_cnt;
    logic [DATA_W-1:0]  res_sr;
    logic               take;
    logic               load_now;
    logic               timeout_now;
    logic [DATA_W-1:0]  load_word;

    assign take = en && ((state == ST_IDLE) || (state == ST_LOAD));

    aes_nib_shifter #(.DATA_W(DATA_W), .NIB_W(NIB_W)) u_block_sr (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (take),
        .nib   (block),
        .word  (core_block)
    );

    aes_nib_shifter #(.DATA_W(DATA_W), .NIB_W(NIB_W)) u_key_sr (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (take),
        .nib   (key),
        .word  (core_key)
    );

    // Every entry into UNLOAD goes through one load path; core_done beats the timeout.
    always_comb begin
        load_now    = 1'b0;
        timeout_now = 1'b0;
        load_word   = '0;
        if ((state == ST_START) && test_q) begin
            load_now  = 1'b1;
            load_word = core_block ^ core_key;
        end else if (state == ST_WAIT) begin
            if (core_done) begin
                load_now  = 1'b1;
                load_word = core_result;
            end else if (wait_cnt == WAIT_LAST) begin
                load_now    = 1'b1;
                timeout_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            test_q     <= 1'b0;
            nib_cnt    <= '0;
            wait_cnt   <= '0;
            byte_cnt   <= '0;
            res_sr     <= '0;
            result     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            if (load_now) begin
                result   <= load_word[DATA_W-1 -: OUT_W];
                res_sr   <= load_word << OUT_W;
                done     <= 1'b1;
                byte_cnt <= '0;
                state    <= ST_UNLOAD;
                if (timeout_now) begin
                    err <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (en) begin
                            nib_cnt <= NIB_ONE;
                            err     <= 1'b0;
                            state   <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (en) begin
                            nib_cnt <= nib_cnt + NIB_ONE;
                            if (nib_cnt == NIB_LAST) begin
                                test_q     <= test;
                                core_start <= !test;
                                state      <= ST_START;
                            end
                        end
                    end
                    ST_START: begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                    ST_UNLOAD: begin
                        if (byte_cnt == BYTE_LAST) begin
                            result <= '0;
                            done   <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            result   <= res_sr[DATA_W-1 -: OUT_W];
                            res_sr   <= res_sr << OUT_W;
                            byte_cnt <= byte_cnt + BYTE_ONE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_io_sequencer.sv
// Randomised scoreboard bench: stimulus pushes expected bytes, a monitor pops on every done byte.
`timescale 1ns/1ps
module tb_aes_io_sequencer;
    import aes_pkg::*;

    localparam int WMAX = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         test = 1'b0;
    logic [3:0]   block = '0;
    logic [3:0]   key = '0;
    logic [7:0]   result;
    logic         done;
    logic         err;
    logic         core_start;
    logic [127:0] core_block;
    logic [127:0] core_key;
    logic         core_done;
    logic [127:0] core_result;

    logic         model_done = 1'b0;
    logic [127:0] model_res = '0;
    logic         stray_done = 1'b0;
    logic [127:0] stray_res = '0;

    assign core_done   = model_done | stray_done;
    assign core_result = model_done ? model_res : stray_res;

    aes_io_sequencer #(.DATA_W(128), .NIB_W(4), .OUT_W(8), .WAIT_MAX(WMAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .test        (test),
        .block       (block),
        .key         (key),
        .result      (result),
        .done        (done),
        .err         (err),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_result (core_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] b;
        logic       e;
        int         c;
        bit         last;
    } exp_t;
    exp_t sb[$];

    logic [127:0] op_block, op_key, op_core_res;
    int  op_delay = 0;
    int  op_stall = 0;
    int  op_first_cyc = 0;
    bit  expect_start = 1'b0;
    int  ops_done = 0;
    int  op_target = 0;
    int  bytes_seen = 0;
    int  starts_seen = 0;
    int  exp_starts = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected bytes of one result word, most significant first, presented on consecutive cycles.
    task automatic push_word(input logic [127:0] w, input logic e, input int first_cyc);
        for (int i = 0; i < BYTES; i++) begin
            exp_t x;
            x.b    = w[127-8*i -: 8];
            x.e    = e;
            x.c    = first_cyc + i;
            x.last = (i == BYTES - 1);
            sb.push_back(x);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: result %h with empty scoreboard (cycle %0d)", result, cyc);
                end else begin
                    x = sb.pop_front();
                    check("result_byte", result, x.b);
                    check("err_during_unload", err, x.e);
                    check("byte_cycle", cyc, x.c);
                    bytes_seen++;
                    if (x.last) ops_done++;
                end
            end else begin
                check("result_zero_when_idle", result, 0);
            end
        end
    end

    // Core model: responds op_delay cycles after the start pulse (late responses land outside WAIT).
    initial begin : core_model
        int s;
        forever begin
            @(negedge clk);
            if (rst_n && core_start) begin
                s = cyc;
                starts_seen++;
                if (!expect_start) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_core_start: got 1 expected 0 (cycle %0d)", s);
                end else begin
                    check("core_block", core_block, op_block);
                    check("core_key", core_key, op_key);
                    check("start_latency", s - op_first_cyc, 32 + op_stall);
                    if (op_delay <= WMAX) push_word(op_core_res, 1'b0, s + op_delay + 1);
                    else                  push_word('0, 1'b1, s + WMAX + 1);
                    repeat (op_delay) @(negedge clk);
                    model_done = 1'b1;
                    model_res  = op_core_res;
                    @(negedge clk);
                    model_done = 1'b0;
                    model_res  = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    task automatic wait_done_bounded(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One complete operation. stall_a/stall_b: nibble index before which en drops for 3 cycles.
    task automatic run_op(input logic [127:0] blk, input logic [127:0] k, input bit tm,
                          input int stall_a, input int stall_b, input int delay,
                          input logic [127:0] cres, input bit stray, input bit hold_en,
                          input int rst_byte);
        int  last_cyc;
        int  base;
        bit  ok;
        bit  exp_err;
        op_block     = blk;
        op_key       = k;
        op_delay     = delay;
        op_core_res  = cres;
        op_stall     = 0;
        expect_start = !tm;
        last_cyc     = 0;
        for (int i = 0; i < NIBBLES; i++) begin
            @(negedge clk);
            if (i == 1) check("err_clear_on_load", err, 0);
            if (i == stall_a || i == stall_b) begin
                en         = 1'b0;
                block      = 4'($urandom);
                key        = 4'($urandom);
                stray_res  = {$urandom, $urandom, $urandom, $urandom};
                stray_done = stray;
                @(negedge clk);
                stray_done = 1'b0;
                repeat (2) @(negedge clk);
                if (i > 0) op_stall += 3;
            end
            en    = 1'b1;
            block = blk[127-4*i -: 4];
            key   = k[127-4*i -: 4];
            test  = (i == NIBBLES - 1) ? tm : !tm;
            if (i == 0) op_first_cyc = cyc;
            if (i == NIBBLES - 1) last_cyc = cyc;
        end
        @(negedge clk);
        en   = 1'b0;
        test = 1'b0;
        if (tm) push_word(blk ^ k, 1'b0, last_cyc + 2);
        else    exp_starts++;

        if (rst_byte > 0) begin
            base = bytes_seen;
            ok   = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                #1;
                if (bytes_seen >= base + rst_byte) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL reset_wait_timeout: saw %0d bytes expected %0d", bytes_seen - base, rst_byte);
            end
            #1 rst_n = 1'b0;
            #1;
            check("async_reset_done", done, 0);
            check("async_reset_result", result, 0);
            check("async_reset_core_block", core_block, 0);
            check("async_reset_err", err, 0);
            sb.delete();
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end

        op_target++;
        if (hold_en) begin
            wait_done_bounded(200, ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL done_never_rose: got 0 expected 1");
            end
            repeat (8) begin
                en    = 1'b1;
                block = 4'($urandom);
                key   = 4'($urandom);
                @(negedge clk);
            end
            en = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ops_done >= op_target && !done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL op_timeout: ops_done %0d expected %0d", ops_done, op_target);
        end
        @(negedge clk);
        exp_err = !tm && (delay > WMAX);
        check("err_sticky_after_op", err, exp_err);
        check("core_block_stable", core_block, blk);
        check("core_key_stable", core_key, k);
        check("core_start_count", starts_seen, exp_starts);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [127:0] fips_key = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] fips_blk = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] fips_res = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin : stimulus
        logic [127:0] rb, rk, rr;
        bit           tm;
        int           sa, sbi, dly;
        #1;
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_err", err, 0);
        check("reset_core_start", core_start, 0);
        check("reset_core_block", core_block, 0);
        check("reset_core_key", core_key, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(fips_blk, fips_key, 1'b0, -1, -1, 10, fips_res, 1'b0, 1'b0, 0);
        run_op(fips_blk, fips_key, 1'b0, 5, 20, 10, fips_res, 1'b0, 1'b0, 0);
        run_op({32{4'ha}}, {32{4'h5}}, 1'b1, -1, -1, 0, '0, 1'b0, 1'b0, 0);
        run_op(fips_blk, fips_key, 1'b0, -1, -1, 25, fips_res, 1'b0, 1'b0, 0);
        run_op(fips_blk, fips_key, 1'b0, -1, -1, WMAX, fips_res, 1'b0, 1'b0, 0);
        run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               1'b1, -1, -1, 0, '0, 1'b0, 1'b0, 7);
        run_op(fips_blk, fips_key, 1'b0, -1, -1, 3, fips_res, 1'b0, 1'b0, 0);
        run_op(fips_blk, fips_key, 1'b0, 0, 10, 1, fips_res, 1'b1, 1'b1, 0);

        for (int n = 0; n < 14; n++) begin
            rb  = {$urandom, $urandom, $urandom, $urandom};
            rk  = {$urandom, $urandom, $urandom, $urandom};
            rr  = {$urandom, $urandom, $urandom, $urandom};
            tm  = ($urandom_range(0, 3) == 0);
            sa  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 31));
            sbi = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 31));
            dly = int'($urandom_range(1, WMAX + 6));
            run_op(rb, rk, tm, sa, sbi, dly, rr, bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
